// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem request at a time
// and holds a single fetched instruction for decode behind a valid/ready handshake.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        br_valid_i,
    input  logic        PC_sel_i,
    input  logic [31:0] br_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        flush_o
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DROP  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;

    logic redirect;
    logic req;
    logic fire;

    assign redirect = br_valid_i & PC_sel_i;
    // A new request may only go out if the buffer will be free when its response lands.
    assign req  = (state_q == S_FETCH) && (!valid_q || instr_ready_i);
    assign fire = req & imem_gnt_i;

    always_comb begin
        // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;

        if (redirect) begin
            pc_d    = {br_target_i[31:2], 2'b00};
            valid_d = 1'b0;
            case (state_q)
                S_FETCH: if (fire) state_d = S_DROP;
                S_WAIT:  state_d = imem_rvalid_i ? S_FETCH : S_DROP;
                S_DROP:  if (imem_rvalid_i) state_d = S_FETCH;
                default: state_d = S_FETCH;
            endcase
        end else begin
            if (valid_q && instr_ready_i) valid_d = 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (fire) begin
                        state_d = S_WAIT;
                        pc_d    = pc_q + 32'd4;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        state_d    = S_FETCH;
                        valid_d    = 1'b1;
                        instr_d    = imem_rdata_i;
                        instr_pc_d = pc_q - 32'd4;
                    end
                end
                S_DROP:  if (imem_rvalid_i) state_d = S_FETCH;
                default: state_d = S_FETCH;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign imem_req_o    = req;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = valid_q ? instr_q : NOP_INSTR;
    assign instr_pc_o    = instr_pc_q;
    assign flush_o       = redirect & ~rst_i;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios followed by random branch/stall/memory
// traffic, all checked against a transaction-level model of the fetch stage.
module tb_pc_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_valid = 1'b0;
    logic        pc_sel = 1'b0;
    logic [31:0] br_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        flush;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: next fetch address, the single outstanding request, the buffer.
    logic [31:0] m_fetch_pc;
    logic        m_pending;
    logic        m_stale;
    logic [31:0] m_addr;
    int          m_delay;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;

    pc_fetch_unit dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .br_valid_i    (br_valid),
        .PC_sel_i      (pc_sel),
        .br_target_i   (br_target),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .flush_o       (flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic model_reset();
        m_fetch_pc = 32'h0;
        m_pending  = 1'b0;
        m_stale    = 1'b0;
        m_addr     = '0;
        m_delay    = 0;
        m_valid    = 1'b0;
        m_instr    = NOP;
        m_ipc      = 32'h0;
    endtask

    // One clock cycle: drive inputs, play the memory, check outputs, advance the model.
    // gnt_pct is the grant probability; dly<0 picks a random response latency.
    task automatic step(input logic br, input logic sel, input logic [31:0] tgt,
                        input logic rdy, input int gnt_pct, input int dly);
        logic exp_req;
        logic fire;
        logic redirect;
        @(negedge clk);
        br_valid    = br;
        pc_sel      = sel;
        br_target   = tgt;
        instr_ready = rdy;
        imem_rvalid = m_pending && (m_delay == 0);
        imem_rdata  = imem_rvalid ? mem_word(m_addr) : 32'hDEAD_BEEF;
        if (m_pending && m_delay != 0) m_delay--;
        #1;
        imem_gnt = imem_req && (int'($urandom_range(99)) < gnt_pct);
        #1;
        redirect = br & sel;
        exp_req  = !m_pending && !(m_valid && !rdy);
        check("flush", 32'(flush), 32'(redirect));
        check("req", 32'(imem_req), 32'(exp_req));
        check("addr", imem_addr, m_fetch_pc);
        check("valid", 32'(instr_valid), 32'(m_valid));
        check("instr", instr, m_valid ? m_instr : NOP);
        check("instr_pc", instr_pc, m_ipc);

        fire = imem_gnt && exp_req;
        if (redirect) begin
            m_valid = 1'b0;
        end else begin
            if (m_valid && rdy) m_valid = 1'b0;
            if (imem_rvalid && !m_stale) begin
                m_valid = 1'b1;
                m_instr = imem_rdata;
                m_ipc   = m_addr;
            end
        end
        if (imem_rvalid) m_pending = 1'b0;
        else if (redirect && m_pending) m_stale = 1'b1;
        if (fire) begin
            m_pending = 1'b1;
            m_addr    = m_fetch_pc;
            m_stale   = redirect;
            m_delay   = (dly < 0) ? int'($urandom_range(2)) : dly;
        end
        if (redirect) m_fetch_pc = {tgt[31:2], 2'b00};
        else if (fire) m_fetch_pc = m_fetch_pc + 32'd4;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_req", 32'(imem_req), 32'h1);
        check("rst_instr", instr, NOP);
        rst = 1'b0;

        // First fetch: gnt same cycle, rvalid one cycle later.
        step(1'b0, 1'b0, 32'h0, 1'b1, 100, 0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 0, 0);
        settle();
        check("first_instr", instr, 32'h0050_0093);
        check("first_pc", instr_pc, 32'h0);
        check("first_valid", 32'(instr_valid), 32'h1);
        check("first_next_addr", imem_addr, 32'h4);

        // Decode stall for five cycles, then release with a slow response.
        repeat (5) step(1'b0, 1'b0, 32'h0, 1'b0, 100, 0);
        settle();
        check("stall_addr", imem_addr, 32'h4);
        step(1'b0, 1'b0, 32'h0, 1'b1, 100, 1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 0, 0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 0, 0);

        // Redirect while waiting on addr 8; the late response must be dropped.
        step(1'b0, 1'b0, 32'h0, 1'b1, 100, 1);
        step(1'b1, 1'b1, 32'h100, 1'b1, 0, 0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 100, 0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 100, 0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 0, 0);
        settle();
        check("redir_pc", instr_pc, 32'h100);
        check("redir_instr", instr, mem_word(32'h100));

        // Branch resolved not taken.
        step(1'b1, 1'b0, 32'h200, 1'b1, 100, 0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 0, 0);
        settle();
        check("nt_pc", instr_pc, 32'h104);

        // Redirect coincident with a grant at 0x10.
        step(1'b1, 1'b1, 32'h10, 1'b1, 0, 0);
        step(1'b1, 1'b1, 32'h40, 1'b1, 100, 0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 100, 0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 100, 0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 0, 0);
        settle();
        check("gnt_redir_pc", instr_pc, 32'h40);

        // Misaligned target truncates.
        step(1'b1, 1'b1, 32'h102, 1'b1, 0, 0);
        settle();
        check("misalign_addr", imem_addr, 32'h100);

        // PC wrap at the top of the address space.
        step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 0, 0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 100, 0);
        settle();
        check("wrap_addr", imem_addr, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 0, 0);
        settle();
        check("wrap_pc", instr_pc, 32'hFFFF_FFFC);

        // Asynchronous reset while waiting on a response.
        step(1'b0, 1'b0, 32'h0, 1'b1, 100, 2);
        @(negedge clk);
        br_valid = 1'b1;
        pc_sel   = 1'b1;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_req", 32'(imem_req), 32'h1);
        check("arst_addr", imem_addr, 32'h0);
        check("arst_valid", 32'(instr_valid), 32'h0);
        check("arst_instr", instr, NOP);
        check("arst_pc", instr_pc, 32'h0);
        check("arst_flush", 32'(flush), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        br_valid = 1'b0;

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic        b;
            logic [31:0] t;
            b = ($urandom_range(9) == 0);
            t = ($urandom_range(15) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15))
                                           : 32'($urandom_range(1023));
            step(b, 1'($urandom_range(1)), t, ($urandom_range(3) != 0), 60, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
